// File: rtl/cfs_algn_pkg.sv
// Shared aligner types, width helpers and the transfer legality rule used by RX control and the register block.
package cfs_algn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    RESP = 2'd2
  } cfs_rx_ctrl_state_t;

  function automatic int cfs_algn_offset_width(input int data_width);
    return (data_width <= 8) ? 1 : $clog2(data_width / 8);
  endfunction

  function automatic int cfs_algn_size_width(input int data_width);
    return $clog2(data_width / 8) + 1;
  endfunction

  // Operands arrive zero-extended to 32 bits, which is wider than the rule needs, so no overflow is possible.
  function automatic logic cfs_algn_is_legal(input logic [31:0] bytes,
                                             input logic [31:0] offset,
                                             input logic [31:0] size);
    logic legal;
    legal = 1'b0;
    if (size != 32'd0) begin
      legal = ((offset + size) <= bytes) && (((bytes + offset) % size) == 32'd0);
    end
    return legal;
  endfunction

endpackage

// File: rtl/cfs_rx_ctrl_if.sv
// MD receive bus plus RX FIFO push port of the aligner RX front-end.
interface cfs_rx_ctrl_if
  import cfs_algn_pkg::*;
#(
  parameter int ALGN_DATA_WIDTH = 32
) ();
  localparam int ALGN_OFFSET_WIDTH = cfs_algn_offset_width(ALGN_DATA_WIDTH);
  localparam int ALGN_SIZE_WIDTH   = cfs_algn_size_width(ALGN_DATA_WIDTH);

  logic                         md_rx_valid;
  logic [ALGN_DATA_WIDTH-1:0]   md_rx_data;
  logic [ALGN_OFFSET_WIDTH-1:0] md_rx_offset;
  logic [ALGN_SIZE_WIDTH-1:0]   md_rx_size;
  logic                         md_rx_ready;
  logic                         md_rx_err;
  logic                         push_valid;
  logic [ALGN_DATA_WIDTH-1:0]   push_data;
  logic [ALGN_OFFSET_WIDTH-1:0] push_offset;
  logic [ALGN_SIZE_WIDTH-1:0]   push_size;
  logic                         push_ready;

  modport slave (
    input  md_rx_valid, md_rx_data, md_rx_offset, md_rx_size, push_ready,
    output md_rx_ready, md_rx_err, push_valid, push_data, push_offset, push_size
  );

  modport master (
    output md_rx_valid, md_rx_data, md_rx_offset, md_rx_size, push_ready,
    input  md_rx_ready, md_rx_err, push_valid, push_data, push_offset, push_size
  );
endinterface

// File: rtl/cfs_sat_counter.sv
// W-bit saturating up-counter; clear beats increment, is_max is registered alongside the count.
module cfs_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_is_max
);
  logic [W-1:0] r_cnt;
  logic         r_is_max;
  logic [W-1:0] w_cnt_next;

  always_comb begin
    w_cnt_next = r_cnt;
    if (i_clr) begin
      w_cnt_next = '0;
    end else if (i_inc && !r_is_max) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_is_max <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_is_max <= &w_cnt_next;
    end
  end

  assign o_cnt    = r_cnt;
  assign o_is_max = r_is_max;
endmodule

// File: rtl/cfs_rx_ctrl.sv
// Aligner RX front-end: checks MD transfers, pushes legal ones into the RX FIFO, counts drops.
// Optional macro CFS_RX_CTRL_DROP_ON_FULL_EN: drop legal transfers that arrive while the FIFO is full.
module cfs_rx_ctrl
  import cfs_algn_pkg::*;
#(
  parameter int ALGN_DATA_WIDTH       = 32,
  parameter int STATUS_CNT_DROP_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  cfs_rx_ctrl_if.slave                     md,
  input  logic                             ctrl_clr,
  output logic [STATUS_CNT_DROP_WIDTH-1:0] status_cnt_drop,
  output logic                             max_drop
);
  localparam int ALGN_OFFSET_WIDTH = cfs_algn_offset_width(ALGN_DATA_WIDTH);
  localparam int ALGN_SIZE_WIDTH   = cfs_algn_size_width(ALGN_DATA_WIDTH);
  localparam int BYTES             = ALGN_DATA_WIDTH / 8;

  cfs_rx_ctrl_state_t           r_state;
  cfs_rx_ctrl_state_t           w_state_next;
  logic [ALGN_DATA_WIDTH-1:0]   r_data;
  logic [ALGN_OFFSET_WIDTH-1:0] r_offset;
  logic [ALGN_SIZE_WIDTH-1:0]   r_size;
  logic                         r_err;
  logic                         w_err_next;
  logic                         w_capture;
  logic                         w_drop;
  logic                         w_legal;

  assign w_legal = cfs_algn_is_legal(32'(BYTES), 32'(md.md_rx_offset), 32'(md.md_rx_size));

  always_comb begin
    w_state_next = r_state;
    w_err_next   = r_err;
    w_capture    = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (md.md_rx_valid) begin
          w_capture = 1'b1;
          if (!w_legal) begin
            w_drop       = 1'b1;
            w_err_next   = 1'b1;
            w_state_next = RESP;
          end
`ifdef CFS_RX_CTRL_DROP_ON_FULL_EN
          else if (!md.push_ready) begin
            w_drop       = 1'b1;
            w_err_next   = 1'b0;
            w_state_next = RESP;
          end
`endif
          else begin
            w_err_next   = 1'b0;
            w_state_next = PUSH;
          end
        end
      end
      PUSH: begin
        if (md.push_ready) begin
          w_err_next   = 1'b0;
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_err    <= 1'b0;
      r_data   <= '0;
      r_offset <= '0;
      r_size   <= '0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_err_next;
      if (w_capture) begin
        r_data   <= md.md_rx_data;
        r_offset <= md.md_rx_offset;
        r_size   <= md.md_rx_size;
      end
    end
  end

  // Captured fields only change in IDLE, so they stay stable for the whole PUSH stall.
  assign md.push_valid  = (r_state == PUSH);
  assign md.push_data   = r_data;
  assign md.push_offset = r_offset;
  assign md.push_size   = r_size;
  assign md.md_rx_ready = (r_state == RESP);
  assign md.md_rx_err   = r_err && (r_state == RESP);

  cfs_sat_counter #(
    .W(STATUS_CNT_DROP_WIDTH)
  ) u_drop_cnt (
    .clk      (clk),
    .reset    (reset),
    .i_inc    (w_drop),
    .i_clr    (ctrl_clr),
    .o_cnt    (status_cnt_drop),
    .o_is_max (max_drop)
  );
endmodule

// File: tb/tb_cfs_rx_ctrl.sv
// Scoreboard bench for cfs_rx_ctrl: directed transfers queue expected pushes/responses, monitors check them.
module tb_cfs_rx_ctrl;
  typedef struct {
    logic err;
    int   cyc;
  } resp_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  off;
    logic [2:0]  sz;
    int          cyc;
  } push_t;

  logic       clk;
  logic       reset;
  logic       ctrl_clr;
  logic [7:0] status_cnt_drop;
  logic       max_drop;
  int         cyc;
  int         n_tests;
  int         n_fail;
  int         exp_cnt;
  resp_t      exp_resp[$];
  push_t      exp_push[$];

  cfs_rx_ctrl_if #(.ALGN_DATA_WIDTH(32)) bus ();

  cfs_rx_ctrl #(
    .ALGN_DATA_WIDTH(32),
    .STATUS_CNT_DROP_WIDTH(8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .md              (bus),
    .ctrl_clr        (ctrl_clr),
    .status_cnt_drop (status_cnt_drop),
    .max_drop        (max_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every md_rx_ready pulse must match the oldest expected response.
  initial begin : mon_resp
    resp_t e;
    forever begin
      @(negedge clk);
      if (bus.md_rx_ready) begin
        if (exp_resp.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL resp_unexpected: md_rx_ready=1 with no response expected (cycle %0d)", cyc);
        end else begin
          e = exp_resp.pop_front();
          chk("resp_err", 32'(bus.md_rx_err), 32'(e.err));
          chk("resp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Push monitor: fields are checked every cycle push_valid is up, cycle on acceptance.
  initial begin : mon_push
    push_t e;
    forever begin
      @(negedge clk);
      if (bus.push_valid) begin
        if (exp_push.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL push_unexpected: push_valid=1 with no push expected (cycle %0d)", cyc);
        end else begin
          e = exp_push[0];
          chk("push_data", bus.push_data, e.data);
          chk("push_offset", 32'(bus.push_offset), 32'(e.off));
          chk("push_size", 32'(bus.push_size), 32'(e.sz));
          if (bus.push_ready) begin
            chk("push_cycle", 32'(cyc), 32'(e.cyc));
            void'(exp_push.pop_front());
          end
        end
      end
    end
  end

  task automatic chk_cnt();
    @(negedge clk);
    chk("cnt_drop", 32'(status_cnt_drop), 32'(exp_cnt));
    chk("max_drop", 32'(max_drop), 32'(exp_cnt == 255));
  endtask

  task automatic xfer(input logic [1:0] off, input logic [2:0] sz, input logic [31:0] d,
                      input bit legal, input int stall, input bit clr);
    int k;
    int n;
    bit drop;
    @(posedge clk);
    #1;
    k = cyc;
    bus.md_rx_valid  = 1'b1;
    bus.md_rx_offset = off;
    bus.md_rx_size   = sz;
    bus.md_rx_data   = d;
    ctrl_clr         = clr;
    if (stall > 0) bus.push_ready = 1'b0;
    drop = !legal;
`ifdef CFS_RX_CTRL_DROP_ON_FULL_EN
    if (legal && stall > 0) drop = 1'b1;
`endif
    if (!legal) begin
      exp_resp.push_back('{1'b1, k + 1});
    end else if (drop) begin
      exp_resp.push_back('{1'b0, k + 1});
    end else begin
      exp_push.push_back('{d, off, sz, k + 1 + stall});
      exp_resp.push_back('{1'b0, k + 2 + stall});
    end
    if (clr) exp_cnt = 0;
    else if (drop && exp_cnt < 255) exp_cnt++;
    fork
      begin
        if (clr) begin
          @(posedge clk);
          #1 ctrl_clr = 1'b0;
        end
      end
      begin
        if (stall > 0) begin
          repeat (stall + 1) @(posedge clk);
          #1 bus.push_ready = 1'b1;
        end
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!bus.md_rx_ready && n < 64);
        chk("resp_timeout", 32'(bus.md_rx_ready), 32'd1);
        @(posedge clk);
        #1 bus.md_rx_valid = 1'b0;
      end
    join
    chk_cnt();
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 ctrl_clr = 1'b1;
    @(posedge clk);
    #1 ctrl_clr = 1'b0;
    exp_cnt = 0;
    chk_cnt();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    n_tests = 0;
    n_fail  = 0;
    exp_cnt = 0;
    reset            = 1'b1;
    ctrl_clr         = 1'b0;
    bus.md_rx_valid  = 1'b0;
    bus.md_rx_data   = '0;
    bus.md_rx_offset = '0;
    bus.md_rx_size   = '0;
    bus.push_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_push_valid", 32'(bus.push_valid), 32'd0);
    chk("rst_push_data", bus.push_data, 32'd0);
    chk("rst_push_offset", 32'(bus.push_offset), 32'd0);
    chk("rst_push_size", 32'(bus.push_size), 32'd0);
    chk("rst_rx_ready", 32'(bus.md_rx_ready), 32'd0);
    chk("rst_rx_err", 32'(bus.md_rx_err), 32'd0);
    chk("rst_cnt", 32'(status_cnt_drop), 32'd0);
    chk("rst_max", 32'(max_drop), 32'd0);

    // Directed legal / illegal vectors (B=4)
    xfer(2'd0, 3'd4, 32'hDEADBEEF, 1'b1, 0, 1'b0);
    xfer(2'd1, 3'd2, 32'h11111111, 1'b0, 0, 1'b0);
    xfer(2'd2, 3'd2, 32'h22220000, 1'b1, 0, 1'b0);
    xfer(2'd3, 3'd1, 32'h33000000, 1'b1, 0, 1'b0);
    xfer(2'd1, 3'd3, 32'h44444444, 1'b0, 0, 1'b0);
    xfer(2'd3, 3'd2, 32'h55555555, 1'b0, 0, 1'b0);
    xfer(2'd0, 3'd2, 32'h00006666, 1'b1, 0, 1'b0);
    xfer(2'd0, 3'd5, 32'h77777777, 1'b0, 0, 1'b0);
    xfer(2'd1, 3'd1, 32'h00008800, 1'b1, 0, 1'b0);

    // Saturation: 256 size=0 drops from zero
    pulse_clr();
    for (int i = 0; i < 256; i++) xfer(2'(i), 3'd0, 32'(i), 1'b0, 0, 1'b0);

    // Clear racing a drop increment at cnt=7
    pulse_clr();
    for (int i = 0; i < 7; i++) xfer(2'd2, 3'd3, 32'h0, 1'b0, 0, 1'b0);
    xfer(2'd0, 3'd0, 32'h0, 1'b0, 0, 1'b1);

    // Backpressure: FIFO full for 5 cycles of push_valid
    xfer(2'd0, 3'd4, 32'hA5A5F00D, 1'b1, 5, 1'b0);
    xfer(2'd2, 3'd1, 32'h00BB0000, 1'b1, 0, 1'b0);

    // Reset while stalled in PUSH
    xfer(2'd0, 3'd3, 32'h0, 1'b0, 0, 1'b0);
    @(posedge clk);
    #1;
    bus.push_ready   = 1'b0;
    bus.md_rx_valid  = 1'b1;
    bus.md_rx_offset = 2'd0;
    bus.md_rx_size   = 3'd4;
    bus.md_rx_data   = 32'hCAFEF00D;
    exp_push.push_back('{32'hCAFEF00D, 2'd0, 3'd4, -1});
    @(posedge clk);
    #1;
    chk("t6_in_push", 32'(bus.push_valid), 32'd1);
    reset           = 1'b1;
    bus.md_rx_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_push.delete();
    bus.push_ready = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    chk("t6_push_valid", 32'(bus.push_valid), 32'd0);
    chk("t6_rx_ready", 32'(bus.md_rx_ready), 32'd0);
    chk("t6_push_data", bus.push_data, 32'd0);
    chk("t6_cnt", 32'(status_cnt_drop), 32'd0);
    chk("t6_max", 32'(max_drop), 32'd0);
    xfer(2'd0, 3'd4, 32'h12345678, 1'b1, 0, 1'b0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
    chk("push_queue_empty", 32'(exp_push.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
